// File: rtl/cmd_fifo_pattern_player.sv
// Purpose: queued command words played as timed patterns (off/pulse/blink/walk) on a pin bus.
// Latency: write accepted at edge E0 -> FETCH at E1 -> first pattern value on pin_out after E2.
// Backpressure: none; writes while full (and not being read) are dropped and flagged on overflow_sig.
module cmd_fifo_pattern_player #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int OUT_W    = 8,
  parameter int TICK_DIV = 50000
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     write_req,
  input  logic [DATA_W-1:0]        fifo_write_data,
  input  logic                     flush,
  output logic                     full_sig,
  output logic                     empty_sig,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow_sig,
  output logic                     busy,
  output logic                     done_pulse,
  output logic [OUT_W-1:0]         pin_out
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int NW = DATA_W - 2;
  localparam int TW = $clog2(TICK_DIV);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [LW-1:0] LVL_FULL  = LW'(DEPTH);

  typedef enum logic [1:0] {IDLE, FETCH, RUN, DONE} state_t;
  state_t state, state_nxt;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic [LW-1:0]     level_nxt;
  logic              rd_en, wr_en, drop;
  logic [DATA_W-1:0] rd_data;

  logic [DATA_W-1:0] cmd;
  logic [TW-1:0]     tick;
  logic [NW-1:0]     rep;
  logic              tick_wrap, last_tick;
  logic [1:0]        cmd_op;
  logic [NW-1:0]     cmd_arg;

  // The FSM only reads in FETCH, and FETCH is only entered with data present.
  assign rd_en   = (state == FETCH) && !empty_sig && !flush;
  // A full FIFO still accepts a write when a read frees a slot in the same cycle.
  assign wr_en   = write_req && !flush && (!full_sig || rd_en);
  assign drop    = write_req && !flush && !wr_en;
  assign rd_data = mem[rd_ptr];

  assign cmd_op    = cmd[DATA_W-1:DATA_W-2];
  assign cmd_arg   = cmd[NW-1:0];
  assign tick_wrap = (tick == TICK_LAST);
  assign last_tick = tick_wrap && (rep == cmd_arg);

  assign busy       = (state != IDLE);
  assign done_pulse = (state == DONE);

  // First pattern value for an opcode: off, all ones, blink starts on, walk starts at bit 0.
  function automatic logic [OUT_W-1:0] first_pat(input logic [1:0] op);
    case (op)
      2'b00:   first_pat = '0;
      2'b01:   first_pat = '1;
      2'b10:   first_pat = '1;
      default: first_pat = OUT_W'(1);
    endcase
  endfunction

  // Occupancy after this cycle's accepted read/write.
  always_comb begin
    level_nxt = level;
    case ({wr_en, rd_en})
      2'b10:   level_nxt = level + LW'(1);
      2'b01:   level_nxt = level - LW'(1);
      default: level_nxt = level;
    endcase
  end

  // Storage array; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= fifo_write_data;
  end

  // Pointers, level and registered status flags derived from the next level.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      level        <= '0;
      empty_sig    <= 1'b1;
      full_sig     <= 1'b0;
      overflow_sig <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (rd_en) rd_ptr <= rd_ptr + AW'(1);
      level        <= level_nxt;
      empty_sig    <= (level_nxt == '0);
      full_sig     <= (level_nxt == LVL_FULL);
      overflow_sig <= drop;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic; flush returns to IDLE from anywhere.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!empty_sig) state_nxt = FETCH;
      FETCH:   state_nxt = RUN;
      RUN:     if (last_tick) state_nxt = DONE;
      DONE:    state_nxt = empty_sig ? IDLE : FETCH;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Pattern datapath: load on RUN entry, step blink/walk at each tick wrap, blank at the end.
  always_ff @(posedge clk) begin
    if (!rst_n || flush) begin
      cmd     <= '0;
      tick    <= '0;
      rep     <= '0;
      pin_out <= '0;
    end else begin
      case (state)
        FETCH: begin
          cmd     <= rd_data;
          tick    <= '0;
          rep     <= '0;
          pin_out <= first_pat(rd_data[DATA_W-1:DATA_W-2]);
        end
        RUN: begin
          if (tick_wrap) begin
            tick <= '0;
            if (rep == cmd_arg) begin
              pin_out <= '0;
            end else begin
              rep <= rep + NW'(1);
              case (cmd_op)
                2'b10:   pin_out <= ~pin_out;
                2'b11:   pin_out <= {pin_out[OUT_W-2:0], pin_out[OUT_W-1]};
                default: pin_out <= pin_out;
              endcase
            end
          end else begin
            tick <= tick + TW'(1);
          end
        end
        default: pin_out <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_fifo_pattern_player.sv
// Purpose: directed and randomized command sequences checked against a per-tick pattern model.
// Latency: samples on the falling edge after each active edge.
// Backpressure: exercises overflow drop, flush and mid-run reset.
module tb_cmd_fifo_pattern_player;

  localparam int DATA_W   = 8;
  localparam int DEPTH    = 16;
  localparam int OUT_W    = 8;
  localparam int TICK_DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       write_req;
  logic [7:0] fifo_write_data;
  logic       flush;
  logic       full_sig, empty_sig, overflow_sig, busy, done_pulse;
  logic [4:0] level;
  logic [7:0] pin_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] cmdq[$];

  always #5 clk = ~clk;

  cmd_fifo_pattern_player #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .OUT_W(OUT_W), .TICK_DIV(TICK_DIV)
  ) dut (
    .clk(clk), .rst_n(rst_n), .write_req(write_req), .fifo_write_data(fifo_write_data),
    .flush(flush), .full_sig(full_sig), .empty_sig(empty_sig), .level(level),
    .overflow_sig(overflow_sig), .busy(busy), .done_pulse(done_pulse), .pin_out(pin_out)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Pattern value for tick k of a command, straight from the opcode table.
  function automatic logic [7:0] pat(input logic [1:0] op, input int k);
    case (op)
      2'd0:    pat = 8'h00;
      2'd1:    pat = 8'hFF;
      2'd2:    pat = (k % 2 == 0) ? 8'hFF : 8'h00;
      default: pat = 8'(1 << (k % OUT_W));
    endcase
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Write cmdq back-to-back from idle and compare pin_out/done/busy against the expected timeline.
  task automatic run_seq();
    logic [7:0] ep[$];
    bit ed[$];
    bit eb[$];
    int m;
    m = cmdq.size();
    ep.push_back(8'h00); ed.push_back(1'b0); eb.push_back(1'b0);
    ep.push_back(8'h00); ed.push_back(1'b0); eb.push_back(1'b1);
    for (int i = 0; i < m; i++) begin
      logic [7:0] c;
      c = cmdq[i];
      for (int k = 0; k <= int'(c[5:0]); k++)
        for (int r = 0; r < TICK_DIV; r++) begin
          ep.push_back(pat(c[7:6], k)); ed.push_back(1'b0); eb.push_back(1'b1);
        end
      ep.push_back(8'h00); ed.push_back(1'b1); eb.push_back(1'b1);
      if (i < m - 1) begin
        ep.push_back(8'h00); ed.push_back(1'b0); eb.push_back(1'b1);
      end
    end
    ep.push_back(8'h00); ed.push_back(1'b0); eb.push_back(1'b0);
    for (int t = 0; t < ep.size(); t++) begin
      if (t < m) begin
        write_req = 1'b1;
        fifo_write_data = cmdq[t];
      end else begin
        write_req = 1'b0;
      end
      step();
      check($sformatf("pin t=%0d", t), pin_out, ep[t]);
      check($sformatf("done t=%0d", t), done_pulse, ed[t]);
      check($sformatf("busy t=%0d", t), busy, eb[t]);
    end
    write_req = 1'b0;
    check("seq_end_level", level, 0);
    check("seq_end_empty", empty_sig, 1);
  endtask

  initial begin
    int dones, bad, cyc;
    rst_n = 1'b0; write_req = 1'b0; fifo_write_data = 8'h00; flush = 1'b0;
    step(); step();
    check("rst_level", level, 0);
    check("rst_empty", empty_sig, 1);
    check("rst_full", full_sig, 0);
    check("rst_ovf", overflow_sig, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done_pulse, 0);
    check("rst_pin", pin_out, 0);
    rst_n = 1'b1;
    step();

    cmdq = '{8'h42};        run_seq();
    cmdq = '{8'hC9};        run_seq();
    cmdq = '{8'h83, 8'h00}; run_seq();

    // Overflow: stall on a long PULSE, then write DEPTH+1 short words.
    write_req = 1'b1; fifo_write_data = 8'h7F;
    step();
    write_req = 1'b0;
    step(); step(); step();
    check("ovf_pre_level", level, 0);
    check("ovf_pre_pin", pin_out, 8'hFF);
    for (int i = 0; i <= DEPTH; i++) begin
      write_req = 1'b1;
      fifo_write_data = (i < DEPTH) ? 8'h40 : 8'hFF;
      step();
      if (i == DEPTH - 1) begin
        check("ovf_full_level", level, DEPTH);
        check("ovf_full_flag", full_sig, 1);
        check("ovf_none_yet", overflow_sig, 0);
      end
    end
    write_req = 1'b0;
    check("ovf_pulse", overflow_sig, 1);
    check("ovf_level_hold", level, DEPTH);
    check("ovf_full_hold", full_sig, 1);
    step();
    check("ovf_pulse_end", overflow_sig, 0);
    dones = 0; bad = 0; cyc = 0;
    while (busy && cyc < 2000) begin
      if (done_pulse) dones++;
      if (pin_out != 8'h00 && pin_out != 8'hFF) bad++;
      step();
      cyc++;
    end
    check("ovf_drain_timeout", busy, 0);
    check("ovf_done_count", dones, DEPTH + 1);
    check("ovf_extra_never_played", bad, 0);
    check("ovf_drain_empty", empty_sig, 1);

    // Flush mid-run with three words queued and a write in the flush cycle.
    write_req = 1'b1; fifo_write_data = 8'h7F;
    step();
    write_req = 1'b0;
    step(); step();
    for (int i = 0; i < 3; i++) begin
      write_req = 1'b1; fifo_write_data = 8'h41 + 8'(i);
      step();
    end
    write_req = 1'b0;
    step(); step();
    check("fl_pre_level", level, 3);
    check("fl_pre_pin", pin_out, 8'hFF);
    check("fl_pre_busy", busy, 1);
    flush = 1'b1; write_req = 1'b1; fifo_write_data = 8'h55;
    step();
    flush = 1'b0; write_req = 1'b0;
    check("fl_level", level, 0);
    check("fl_empty", empty_sig, 1);
    check("fl_full", full_sig, 0);
    check("fl_pin", pin_out, 0);
    check("fl_busy", busy, 0);
    check("fl_done", done_pulse, 0);
    check("fl_ovf", overflow_sig, 0);
    step();
    check("fl_done_after", done_pulse, 0);
    check("fl_busy_after", busy, 0);
    check("fl_level_after", level, 0);

    // Reset for one edge mid-run with one word queued.
    write_req = 1'b1; fifo_write_data = 8'hC9;
    step();
    fifo_write_data = 8'h41;
    step();
    write_req = 1'b0;
    step(); step(); step();
    check("rr_pre_busy", busy, 1);
    check("rr_pre_level", level, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    check("rr_level", level, 0);
    check("rr_empty", empty_sig, 1);
    check("rr_full", full_sig, 0);
    check("rr_ovf", overflow_sig, 0);
    check("rr_busy", busy, 0);
    check("rr_done", done_pulse, 0);
    check("rr_pin", pin_out, 0);
    step();
    check("rr_done_after", done_pulse, 0);
    cmdq = '{8'h42}; run_seq();

    // Randomized back-to-back command sequences.
    for (int it = 0; it < 6; it++) begin
      int m;
      m = $urandom_range(1, 4);
      cmdq.delete();
      for (int j = 0; j < m; j++)
        cmdq.push_back({2'($urandom), 6'($urandom_range(0, 9))});
      run_seq();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmd_fifo_pattern_player.md
Name: cmd_fifo_pattern_player

Overview:
Parametrised successor to the FIFO-fed beep/LED interface. It embeds its own synchronous command FIFO, so no vendor FIFO IP is needed. A fetch/run state machine decodes each queued command word into a timed output pattern on a generic-width pin bus. It adds pattern modes, a repeat count, a level readout, overflow reporting, flush/abort, and a per-command done strobe. It sits between a command producer (UART/key decoder) and board pins (LEDs, buzzer).

Parameters:
DATA_W, 8, command word width; must be >= 4.
DEPTH, 16, FIFO entries; must be a power of 2 and >= 2.
OUT_W, 8, pin_out width; must be >= 2.
TICK_DIV, 50000, clock cycles per pattern tick (1 ms at 50 MHz); must be >= 2.

Ports:
clk  in  1  system clock; all logic on rising edge
rst_n  in  1  synchronous reset, active-low
write_req  in  1  push fifo_write_data this cycle
fifo_write_data  in  DATA_W  command: [DATA_W-1:DATA_W-2]=opcode, [DATA_W-3:0]=arg N
flush  in  1  synchronous clear of FIFO plus abort of the running command
full_sig  out  1  FIFO holds DEPTH entries
empty_sig  out  1  FIFO holds 0 entries
level  out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
overflow_sig  out  1  one-cycle pulse when a write is dropped
busy  out  1  high in FETCH, RUN or DONE
done_pulse  out  1  one-cycle pulse when a command completes normally
pin_out  out  OUT_W  registered pattern output

Behaviour:
- Reset (rst_n=0 at an edge):
  - pointers=0, level=0, empty_sig=1, full_sig=0.
  - overflow_sig=0, busy=0, done_pulse=0, pin_out=0.
  - FSM=IDLE; tick and repeat counters=0.
- FIFO write:
  - Accepted when write_req=1 and full_sig=0.
  - Also accepted when full_sig=1 and an internal read occurs in the same cycle.
  - Otherwise the word is dropped and overflow_sig=1 on the next cycle only.
- Level: simultaneous accepted read+write leaves level unchanged. Status flags are registered and consistent with level every cycle.
- FIFO read: issued only by the FSM, only when empty_sig=0. Data is registered into the command register on the read edge.
- FSM states and transitions:
  - IDLE -> FETCH when empty_sig=0.
  - FETCH: read issued; cmd register loaded. -> RUN on the next edge.
  - RUN: on entry, pin_out is loaded with the first pattern value and the tick counter is cleared.
  - RUN: the tick counter counts 0..TICK_DIV-1; at wrap the pattern advances and the repeat counter increments.
  - RUN -> DONE at the wrap ending tick N (N+1 ticks total; the repeat counter is compared against N).
  - DONE: pin_out=0, done_pulse=1 for this cycle. -> FETCH if empty_sig=0, else IDLE.
- Latency: write accepted at edge E0 -> FETCH at E1 -> first pattern value visible after E2. pin_out=0 from the DONE edge until the next RUN entry.
- Opcodes (pattern value per tick k = 0..N):
  - 00 HOLD_OFF: pin_out=0 for all ticks (timed gap).
  - 01 PULSE: pin_out=all ones for all ticks.
  - 10 BLINK: all ones on even k, all zeros on odd k.
  - 11 WALK: one-hot 1<<(k mod OUT_W); wraps from bit OUT_W-1 back to bit 0.
- Argument: N is unsigned, 0..2^(DATA_W-2)-1. N=0 gives a single tick.
- Flush (has priority over write_req and FSM progress, below rst_n):
  - Next cycle: FIFO empty (level=0), FSM=IDLE, pin_out=0, busy=0.
  - No done_pulse, no overflow_sig.
  - A write_req in the flush cycle is discarded without an overflow pulse.
- Reset or flush mid-RUN: pattern stops immediately; no done_pulse.
- Writes during RUN are queued normally. Back-to-back commands have exactly 2 cycles of pin_out=0 between them (DONE, FETCH).

Test Plan:
- Reset, then write 8'h42 (PULSE, N=2) with TICK_DIV=4 -> pin_out=8'hFF for exactly 12 cycles starting 2 edges after the write; done_pulse one cycle; busy low after.
- Write 8'hC9 (WALK, N=9) with OUT_W=8 -> pin_out sequence 01,02,04,08,10,20,40,80,01,02, one value per tick, then 0.
- Write 8'h83 (BLINK, N=3) -> FF,00,FF,00 per tick; then write 8'h00 -> HOLD_OFF: pin_out=0 for one tick; two done_pulses total.
- Stall the FSM on a long command; write DEPTH+1 words -> level=DEPTH, full_sig=1, one overflow_sig pulse, the extra word is never played.
- Assert flush mid-RUN with 3 words queued -> next cycle level=0, empty_sig=1, pin_out=0, busy=0, no done_pulse.
- Deassert rst_n for one edge mid-RUN -> all outputs at reset values on the following cycle; subsequent writes play normally.
